// File: rtl/mwr_job_sched.sv
// Job scheduler for the AXI write master: queues write-test descriptors, launches one
// engine run per job, collects response errors, enforces a watchdog, and keeps statistics.
module mwr_job_sched #(
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   job_valid,
   output logic                   job_ready,
   input  logic [63:0]            job_addr,
   input  logic [31:0]            job_init_data,
   input  logic [31:0]            job_pattern,
   input  logic [31:0]            job_number,
   input  logic                   job_wrap_mode,
   input  logic [3:0]             job_wrap_len,
   input  logic                   sched_enable,
   input  logic                   abort,
   input  logic [31:0]            timeout_limit,
   output logic                   engine_start_pulse,
   output logic [63:0]            target_address,
   output logic [31:0]            wr_init_data,
   output logic [31:0]            wr_pattern,
   output logic [31:0]            wr_number,
   output logic                   wrap_mode,
   output logic [3:0]             wrap_len,
   input  logic                   wr_done_pulse,
   input  logic                   wr_error,
   output logic                   busy,
   output logic                   job_done_pulse,
   output logic                   job_err,
   output logic                   timeout_flag,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [CNT_WIDTH-1:0]   jobs_done_cnt,
   output logic [CNT_WIDTH-1:0]   err_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int DW = 165;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      logic [CNT_WIDTH-1:0] r;
      if (v == {CNT_WIDTH{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   state_t               state_q, state_d;
   logic [DW-1:0]        mem_q [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic [DW-1:0]        cfg_q, cfg_d;
   logic                 acc_q, acc_d;
   logic                 aborted_q, aborted_d;
   logic [31:0]          wdog_q, wdog_d;
   logic                 tmo_q, tmo_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [CNT_WIDTH-1:0] jobs_q, jobs_d, errc_q, errc_d;

   logic                 full_s, ready_s, push_s, pop_s, start_s, launch_s, fin_s;
   logic [DW-1:0]        wdata_s, head_s;

   // Descriptor packing: {addr, init, pattern, number, wrap_mode, wrap_len}
   assign wdata_s  = {job_addr, job_init_data, job_pattern, job_number, job_wrap_mode, job_wrap_len};
   assign head_s   = mem_q[rd_ptr_q];
   assign full_s   = (level_q == LW'(DEPTH));
   assign ready_s  = rst_n && !full_s && !abort;
   assign push_s   = job_valid && ready_s;
   assign launch_s = (level_q != {LW{1'b0}}) && sched_enable && !abort;

   // FIFO pointer and level next-state; abort flushes everything
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (abort) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         level_d  = {LW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         level_d = level_q + LW'(push_s) - LW'(pop_s);
      end
   end

   // Descriptor storage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= wdata_s;
      end
   end

   // Sequencer next-state and datapath updates
   always_comb begin
      state_d   = state_q;
      pop_s     = 1'b0;
      start_s   = 1'b0;
      fin_s     = 1'b0;
      cfg_d     = cfg_q;
      acc_d     = acc_q;
      aborted_d = aborted_q;
      wdog_d    = wdog_q;
      tmo_d     = tmo_q;
      done_d    = 1'b0;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (launch_s) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               pop_s     = 1'b1;
               cfg_d     = head_s;
               acc_d     = 1'b0;
               aborted_d = 1'b0;
               wdog_d    = 32'd0;
               // The master ignores number 0, so such jobs finish without a start
               if (head_s[36:5] == 32'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b0;
                  fin_s   = 1'b1;
               end else begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               start_s = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            acc_d     = acc_q | wr_error;
            aborted_d = aborted_q | abort;
            wdog_d    = wdog_q + 32'd1;
            // In-flight AXI traffic cannot be cancelled: abort only marks the job
            if (wr_done_pulse) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = acc_q | wr_error | aborted_q | abort;
               fin_s   = 1'b1;
            end else if ((timeout_limit != 32'd0) && ((wdog_q + 32'd1) == timeout_limit)) begin
               tmo_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DONE: begin
            if (launch_s) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALT: begin
            if (abort) begin
               tmo_d   = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_HALT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Saturating statistics next-state
   always_comb begin
      jobs_d = jobs_q;
      errc_d = errc_q;
      if (fin_s) begin
         jobs_d = sat_inc(jobs_q);
         if (err_d) begin
            errc_d = sat_inc(errc_q);
         end else begin
            errc_d = errc_q;
         end
      end else begin
         jobs_d = jobs_q;
      end
   end

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FIFO control, job configuration, status and counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= {PW{1'b0}};
         rd_ptr_q  <= {PW{1'b0}};
         level_q   <= {LW{1'b0}};
         cfg_q     <= {DW{1'b0}};
         acc_q     <= 1'b0;
         aborted_q <= 1'b0;
         wdog_q    <= 32'd0;
         tmo_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         jobs_q    <= {CNT_WIDTH{1'b0}};
         errc_q    <= {CNT_WIDTH{1'b0}};
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         cfg_q     <= cfg_d;
         acc_q     <= acc_d;
         aborted_q <= aborted_d;
         wdog_q    <= wdog_d;
         tmo_q     <= tmo_d;
         done_q    <= done_d;
         err_q     <= err_d;
         jobs_q    <= jobs_d;
         errc_q    <= errc_d;
      end
   end

   assign job_ready          = ready_s;
   assign engine_start_pulse = start_s;
   assign target_address     = cfg_q[164:101];
   assign wr_init_data       = cfg_q[100:69];
   assign wr_pattern         = cfg_q[68:37];
   assign wr_number          = cfg_q[36:5];
   assign wrap_mode          = cfg_q[4];
   assign wrap_len           = cfg_q[3:0];
   assign busy               = (state_q != S_IDLE);
   assign job_done_pulse     = done_q;
   assign job_err            = err_q;
   assign timeout_flag       = tmo_q;
   assign fifo_level         = level_q;
   assign jobs_done_cnt      = jobs_q;
   assign err_cnt            = errc_q;

endmodule

// File: tb/tb_mwr_job_sched.sv
// Directed bench for mwr_job_sched: one task per scenario, hand-computed cycle expectations.
module tb_mwr_job_sched;
   localparam int DEPTH     = 4;
   localparam int CNT_WIDTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst_n, job_valid, job_ready, job_wrap_mode, sched_enable, abort;
   logic [63:0]            job_addr, target_address;
   logic [31:0]            job_init_data, job_pattern, job_number, timeout_limit;
   logic [3:0]             job_wrap_len, wrap_len;
   logic                   engine_start_pulse, wrap_mode, wr_done_pulse, wr_error;
   logic [31:0]            wr_init_data, wr_pattern, wr_number;
   logic                   busy, job_done_pulse, job_err, timeout_flag;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [CNT_WIDTH-1:0]   jobs_done_cnt, err_cnt;

   logic wr_done_task;
   logic wr_done_stub = 1'b0;
   assign wr_done_pulse = wr_done_task | wr_done_stub;

   int n_pass   = 0;
   int n_checks = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Master stub: done a fixed latency after each start
   logic stub_en  = 1'b0;
   int   stub_lat = 20;
   int   done_at  = -1;
   always @(negedge clk) if (stub_en && engine_start_pulse) done_at = cyc + stub_lat;
   always @(posedge clk) begin
      #1;
      wr_done_stub = stub_en && (cyc == done_at);
   end

   int          start_cyc_q[$];
   logic [63:0] start_addr_q[$];
   always @(negedge clk) begin
      if (engine_start_pulse) begin
         start_cyc_q.push_back(cyc);
         start_addr_q.push_back(target_address);
      end
   end

   mwr_job_sched #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
      .job_addr(job_addr), .job_init_data(job_init_data), .job_pattern(job_pattern),
      .job_number(job_number), .job_wrap_mode(job_wrap_mode), .job_wrap_len(job_wrap_len),
      .sched_enable(sched_enable), .abort(abort), .timeout_limit(timeout_limit),
      .engine_start_pulse(engine_start_pulse), .target_address(target_address),
      .wr_init_data(wr_init_data), .wr_pattern(wr_pattern), .wr_number(wr_number),
      .wrap_mode(wrap_mode), .wrap_len(wrap_len), .wr_done_pulse(wr_done_pulse),
      .wr_error(wr_error), .busy(busy), .job_done_pulse(job_done_pulse), .job_err(job_err),
      .timeout_flag(timeout_flag), .fifo_level(fifo_level), .jobs_done_cnt(jobs_done_cnt),
      .err_cnt(err_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] a, input logic [31:0] p, input logic [31:0] n, output logic acc);
      job_valid = 1'b1; job_addr = a; job_init_data = a[31:0] ^ 32'hA5A5_0000;
      job_pattern = p; job_number = n; job_wrap_mode = n[0]; job_wrap_len = n[3:0];
      @(negedge clk);
      acc = job_ready;
      tick();
      job_valid = 1'b0;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0; job_valid = 1'b0; sched_enable = 1'b0; abort = 1'b0; timeout_limit = 32'd0;
      wr_done_task = 1'b0; wr_error = 1'b0; stub_en = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      @(negedge clk);
      n_checks++; if (job_ready !== 1'b0) $display("FAIL reset_ready: got %0h exp 0", job_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0h exp 0", busy); else n_pass++;
      n_checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d exp 0", fifo_level); else n_pass++;
      n_checks++; if (target_address !== 64'd0) $display("FAIL reset_addr: got %0h exp 0", target_address); else n_pass++;
      n_checks++; if ({jobs_done_cnt, err_cnt} !== 32'd0) $display("FAIL reset_cnts: got %0h exp 0", {jobs_done_cnt, err_cnt}); else n_pass++;
      n_checks++; if ({job_done_pulse, job_err, timeout_flag, engine_start_pulse} !== 4'd0)
         $display("FAIL reset_flags: got %0h exp 0", {job_done_pulse, job_err, timeout_flag, engine_start_pulse}); else n_pass++;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (job_ready !== 1'b1) $display("FAIL release_ready: got %0h exp 1", job_ready); else n_pass++;
   endtask

   task automatic test_single_job();
      logic acc;
      int bad_start, bad_hold, bad_done;
      do_reset();
      sched_enable = 1'b1;
      bad_start = 0; bad_hold = 0; bad_done = 0;
      push(64'h1000, 32'h0003_0F06, 32'd8, acc);
      n_checks++; if (acc !== 1'b1) $display("FAIL single_accept: got %0h exp 1", acc); else n_pass++;
      for (int k = 1; k <= 43; k++) begin
         wr_done_task = (k == 40);
         @(negedge clk);
         if (k == 1) begin
            n_checks++; if (fifo_level !== 3'd1) $display("FAIL single_level1: got %0d exp 1", fifo_level); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_c1: got %0h exp 0", busy); else n_pass++;
         end
         if (k == 3) begin
            n_checks++; if (wr_number !== 32'd8) $display("FAIL single_number: got %0d exp 8", wr_number); else n_pass++;
            n_checks++; if (fifo_level !== 3'd0) $display("FAIL single_level3: got %0d exp 0", fifo_level); else n_pass++;
         end
         if (engine_start_pulse !== (k == 3)) bad_start++;
         if (k >= 3 && k <= 41 && (target_address !== 64'h1000 || wr_pattern !== 32'h0003_0F06)) bad_hold++;
         if (job_done_pulse !== (k == 41)) bad_done++;
         if (k == 41) begin
            n_checks++; if (job_err !== 1'b0) $display("FAIL single_err: got %0h exp 0", job_err); else n_pass++;
         end
         tick();
      end
      wr_done_task = 1'b0;
      n_checks++; if (bad_start !== 0) $display("FAIL single_start_timing: got %0d bad cycles exp 0", bad_start); else n_pass++;
      n_checks++; if (bad_hold !== 0) $display("FAIL single_field_hold: got %0d bad cycles exp 0", bad_hold); else n_pass++;
      n_checks++; if (bad_done !== 0) $display("FAIL single_done_timing: got %0d bad cycles exp 0", bad_done); else n_pass++;
      n_checks++; if (jobs_done_cnt !== 16'd1) $display("FAIL single_jobs_cnt: got %0d exp 1", jobs_done_cnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic acc;
      int base, nd, bad_acc, bad_gap, bad_addr;
      do_reset();
      stub_en = 1'b1; stub_lat = 20;
      base = start_cyc_q.size();
      nd = 0; bad_acc = 0; bad_gap = 0; bad_addr = 0;
      for (int i = 0; i < 4; i++) begin
         push(64'h2000 + 64'(i) * 64'h100, 32'h1111_0000 + 32'(i), 32'(i + 1), acc);
         if (acc !== 1'b1) bad_acc++;
      end
      @(negedge clk);
      n_checks++; if (bad_acc !== 0) $display("FAIL b2b_accepts: got %0d rejected exp 0", bad_acc); else n_pass++;
      n_checks++; if (job_ready !== 1'b0) $display("FAIL b2b_full_ready: got %0h exp 0", job_ready); else n_pass++;
      n_checks++; if (fifo_level !== 3'd4) $display("FAIL b2b_full_level: got %0d exp 4", fifo_level); else n_pass++;
      tick();
      push(64'h9999, 32'h0, 32'd9, acc);
      n_checks++; if (acc !== 1'b0) $display("FAIL b2b_fifth_push: got %0h exp 0", acc); else n_pass++;
      sched_enable = 1'b1;
      for (int t = 0; t < 300 && nd < 4; t++) begin
         @(negedge clk);
         if (job_done_pulse) nd++;
         tick();
      end
      n_checks++; if (nd !== 4) $display("FAIL b2b_done_count: got %0d exp 4", nd); else n_pass++;
      n_checks++; if (start_cyc_q.size() - base !== 4) $display("FAIL b2b_start_count: got %0d exp 4", start_cyc_q.size() - base); else n_pass++;
      for (int i = 0; i < 4 && base + i < start_cyc_q.size(); i++) begin
         if (start_addr_q[base + i] !== 64'h2000 + 64'(i) * 64'h100) bad_addr++;
         if (i > 0 && start_cyc_q[base + i] - start_cyc_q[base + i - 1] !== 23) bad_gap++;
      end
      n_checks++; if (bad_addr !== 0) $display("FAIL b2b_fifo_order: got %0d bad exp 0", bad_addr); else n_pass++;
      n_checks++; if (bad_gap !== 0) $display("FAIL b2b_start_spacing: got %0d bad gaps exp 0", bad_gap); else n_pass++;
      n_checks++; if (jobs_done_cnt !== 16'd4) $display("FAIL b2b_jobs_cnt: got %0d exp 4", jobs_done_cnt); else n_pass++;
      stub_en = 1'b0;
   endtask

   task automatic test_errors();
      logic acc;
      logic [1:0] errs;
      int nst, nd, s;
      do_reset();
      sched_enable = 1'b1;
      nst = 0; nd = 0; s = 0; errs = 2'b00;
      push(64'h7000, 32'h0, 32'd4, acc);
      push(64'h7100, 32'h0, 32'd6, acc);
      for (int t = 0; t < 200 && nd < 2; t++) begin
         wr_done_task = (nst > 0) && (cyc == s + 10);
         wr_error = ((nst == 1) && (cyc == s + 5)) || ((nst == 2) && (cyc == s + 10));
         @(negedge clk);
         if (engine_start_pulse) begin nst++; s = cyc; end
         if (job_done_pulse) begin errs[nd] = job_err; nd++; end
         if (nd < 2) tick();
      end
      n_checks++; if (nd !== 2) $display("FAIL err_done_count: got %0d exp 2", nd); else n_pass++;
      n_checks++; if (errs !== 2'b11) $display("FAIL err_job_err: got %b exp 11", errs); else n_pass++;
      n_checks++; if (err_cnt !== 16'd2) $display("FAIL err_cnt: got %0d exp 2", err_cnt); else n_pass++;
      tick();
      wr_done_task = 1'b0; wr_error = 1'b0;
   endtask

   task automatic test_zero_len();
      logic acc;
      int nst, nd, s, dc0, dc1;
      logic [31:0] num2;
      do_reset();
      sched_enable = 1'b1;
      nst = 0; nd = 0; s = 0; dc0 = 0; dc1 = 0; num2 = 32'd0;
      push(64'h3000, 32'h0, 32'd4, acc);
      push(64'h3100, 32'h0, 32'd0, acc);
      push(64'h3200, 32'h0, 32'd5, acc);
      for (int t = 0; t < 300 && nd < 3; t++) begin
         wr_done_task = (nst > 0) && (cyc == s + 6);
         @(negedge clk);
         if (engine_start_pulse) begin nst++; s = cyc; if (nst == 2) num2 = wr_number; end
         if (job_done_pulse) begin
            if (nd == 0) dc0 = cyc;
            if (nd == 1) dc1 = cyc;
            nd++;
         end
         if (nd < 3) tick();
      end
      n_checks++; if (nd !== 3) $display("FAIL zero_done_count: got %0d exp 3", nd); else n_pass++;
      n_checks++; if (nst !== 2) $display("FAIL zero_start_count: got %0d exp 2", nst); else n_pass++;
      n_checks++; if (dc1 - dc0 !== 2) $display("FAIL zero_done_gap: got %0d exp 2", dc1 - dc0); else n_pass++;
      n_checks++; if (s - dc0 !== 4) $display("FAIL zero_third_start: got %0d exp 4", s - dc0); else n_pass++;
      n_checks++; if (num2 !== 32'd5) $display("FAIL zero_third_number: got %0d exp 5", num2); else n_pass++;
      n_checks++; if (jobs_done_cnt !== 16'd3) $display("FAIL zero_jobs_cnt: got %0d exp 3", jobs_done_cnt); else n_pass++;
      tick();
      wr_done_task = 1'b0;
   endtask

   task automatic test_timeout();
      logic acc;
      int s, tf, extra;
      do_reset();
      timeout_limit = 32'd50;
      sched_enable = 1'b1;
      s = -1000; tf = -1; extra = 0;
      push(64'h4000, 32'h0, 32'd3, acc);
      for (int t = 0; t < 200 && tf < 0; t++) begin
         @(negedge clk);
         if (engine_start_pulse) s = cyc;
         if (timeout_flag === 1'b1) tf = cyc;
         tick();
      end
      n_checks++; if (tf - s !== 51) $display("FAIL tmo_flag_timing: got %0d exp 51", tf - s); else n_pass++;
      push(64'h4100, 32'h0, 32'd2, acc);
      n_checks++; if (acc !== 1'b1) $display("FAIL tmo_halt_push: got %0h exp 1", acc); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (engine_start_pulse) extra++;
         tick();
      end
      @(negedge clk);
      n_checks++; if (extra !== 0) $display("FAIL tmo_halt_no_start: got %0d exp 0", extra); else n_pass++;
      n_checks++; if ({busy, timeout_flag, fifo_level} !== 5'b11001) $display("FAIL tmo_halt_hold: got %b exp 11001", {busy, timeout_flag, fifo_level}); else n_pass++;
      tick();
      abort = 1'b1;
      @(negedge clk);
      n_checks++; if (job_ready !== 1'b0) $display("FAIL tmo_abort_ready: got %0h exp 0", job_ready); else n_pass++;
      tick();
      abort = 1'b0;
      @(negedge clk);
      n_checks++; if ({busy, timeout_flag, fifo_level} !== 5'b00000) $display("FAIL tmo_abort_clear: got %b exp 00000", {busy, timeout_flag, fifo_level}); else n_pass++;
      tick();
   endtask

   task automatic test_abort_wait();
      logic acc;
      int s, dk, extra;
      logic derr;
      do_reset();
      sched_enable = 1'b1;
      s = -1; dk = -1; extra = 0; derr = 1'b0;
      push(64'h5000, 32'h0, 32'd2, acc);
      push(64'h5100, 32'h0, 32'd2, acc);
      push(64'h5200, 32'h0, 32'd2, acc);
      for (int t = 0; t < 20 && s < 0; t++) begin
         @(negedge clk);
         if (engine_start_pulse) s = cyc;
         tick();
      end
      n_checks++; if (s < 0) $display("FAIL abort_first_start: got none exp one"); else n_pass++;
      for (int k = 1; k <= 22; k++) begin
         abort = (k == 3);
         wr_done_task = (k == 8);
         @(negedge clk);
         if (k == 4) begin
            n_checks++; if ({busy, fifo_level} !== 4'b1000) $display("FAIL abort_flush: got %b exp 1000", {busy, fifo_level}); else n_pass++;
         end
         if (engine_start_pulse) extra++;
         if (job_done_pulse) begin dk = k; derr = job_err; end
         tick();
      end
      abort = 1'b0; wr_done_task = 1'b0;
      @(negedge clk);
      n_checks++; if (dk !== 9) $display("FAIL abort_done_timing: got %0d exp 9", dk); else n_pass++;
      n_checks++; if (derr !== 1'b1) $display("FAIL abort_job_err: got %0h exp 1", derr); else n_pass++;
      n_checks++; if (extra !== 0) $display("FAIL abort_no_more_starts: got %0d exp 0", extra); else n_pass++;
      n_checks++; if ({busy, jobs_done_cnt, err_cnt} !== {1'b0, 16'd1, 16'd1}) $display("FAIL abort_idle_cnts: got %h exp 000010001", {busy, jobs_done_cnt, err_cnt}); else n_pass++;
      tick();
      push(64'h6000, 32'h0, 32'd2, acc);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) $display("FAIL rst_pre_wait: got %0h exp 1", busy); else n_pass++;
      tick();
      @(negedge clk);
      n_checks++; if ({job_ready, busy, fifo_level, job_err, timeout_flag, engine_start_pulse} !== 8'd0)
         $display("FAIL rst_mid_flags: got %b exp 0", {job_ready, busy, fifo_level, job_err, timeout_flag, engine_start_pulse}); else n_pass++;
      n_checks++; if ({target_address, wr_number, jobs_done_cnt, err_cnt} !== 128'd0)
         $display("FAIL rst_mid_regs: got %h exp 0", {target_address, wr_number, jobs_done_cnt, err_cnt}); else n_pass++;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; job_valid = 1'b0; job_addr = 64'd0; job_init_data = 32'd0; job_pattern = 32'd0;
      job_number = 32'd0; job_wrap_mode = 1'b0; job_wrap_len = 4'd0; sched_enable = 1'b0;
      abort = 1'b0; timeout_limit = 32'd0; wr_done_task = 1'b0; wr_error = 1'b0;
      test_reset();
      test_single_job();
      test_back_to_back();
      test_errors();
      test_zero_len();
      test_timeout();
      test_abort_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish exp finish before 500000");
      $fatal(1, "simulation time limit reached");
   end

endmodule
